// File: rtl/pr_bus_arbiter_if.sv
// pr_bus_arbiter_if
//  Bundles the two master request/response channels and the peripheral (Pr)
//  bridge channel that pr_bus_arbiter shares between them.
//  Modports:
//   slave  - the arbiter side: takes requests and pr_rd, drives acks, read data,
//            pr_addr/pr_wd/pr_be/pr_we and busy.
//   master - the requesting side (masters plus bridge model): the reverse.
//  Signals:
//   m0_req/m1_req     request, held with its payload until the matching ack
//   m0_addr/m1_addr   30-bit word address [31:2]
//   m0_wd/m1_wd       32-bit write data
//   m0_be/m1_be       4-bit byte enables
//   m0_we/m1_we       1 = write, 0 = read
//   m0_ack/m1_ack     one-cycle completion pulse
//   m0_rd/m1_rd       read data, valid only while the matching ack is high
//   pr_addr/pr_wd/pr_be/pr_we  registered bridge inputs
//   pr_rd             read data returned by the bridge
//   busy              arbiter has a transaction in flight
interface pr_bus_arbiter_if;
   logic        m0_req;
   logic [29:0] m0_addr;
   logic [31:0] m0_wd;
   logic [3:0]  m0_be;
   logic        m0_we;
   logic        m0_ack;
   logic [31:0] m0_rd;

   logic        m1_req;
   logic [29:0] m1_addr;
   logic [31:0] m1_wd;
   logic [3:0]  m1_be;
   logic        m1_we;
   logic        m1_ack;
   logic [31:0] m1_rd;

   logic [29:0] pr_addr;
   logic [31:0] pr_wd;
   logic [3:0]  pr_be;
   logic        pr_we;
   logic [31:0] pr_rd;

   logic        busy;

   modport slave (
      input  m0_req, m0_addr, m0_wd, m0_be, m0_we,
      output m0_ack, m0_rd,
      input  m1_req, m1_addr, m1_wd, m1_be, m1_we,
      output m1_ack, m1_rd,
      output pr_addr, pr_wd, pr_be, pr_we,
      input  pr_rd,
      output busy
   );

   modport master (
      output m0_req, m0_addr, m0_wd, m0_be, m0_we,
      input  m0_ack, m0_rd,
      output m1_req, m1_addr, m1_wd, m1_be, m1_we,
      input  m1_ack, m1_rd,
      input  pr_addr, pr_wd, pr_be, pr_we,
      output pr_rd,
      input  busy
   );
endinterface

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter
//  Shares the peripheral (Pr) bus in front of the device bridge between M0
//  (CPU memory stage) and M1 (DMA/debug port). One transaction at a time is
//  registered onto pr_*, the bridge read latency is waited out, and then the
//  read data and a one-cycle ack are returned to the winning master.
//  Contention is resolved round-robin, and only in IDLE.
//  Parameters:
//   RD_LAT    cycles from pr_* issue to valid pr_rd, legal 1..7
//   M0_FIRST  1: M0 wins the first tie after reset, 0: M1 wins it
//  Ports:
//   clk   single clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   pr_bus_arbiter_if.slave (master channels, bridge channel, busy)
//  Every output is a flop; no request reaches an ack or pr_* output
//  combinationally.
module pr_bus_arbiter #(
   parameter int RD_LAT   = 1,
   parameter bit M0_FIRST = 1'b1
) (
   input logic            clk,
   input logic            rst,
   pr_bus_arbiter_if.slave bus
);

   if (RD_LAT < 1 || RD_LAT > 7) begin : g_rd_lat_check
      $error("pr_bus_arbiter: RD_LAT must be in 1..7");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t      state;
   state_t      next_state;

   // Master encoding for grant/last_grant: 0 = M0, 1 = M1
   logic        grant;
   logic        last_grant;
   logic [2:0]  lat_cnt;

   logic [29:0] pr_addr_q;
   logic [31:0] pr_wd_q;
   logic [3:0]  pr_be_q;
   logic        pr_we_q;
   logic        m0_ack_q;
   logic        m1_ack_q;
   logic [31:0] m0_rd_q;
   logic [31:0] m1_rd_q;
   logic        busy_q;

   logic        any_req;
   logic        pick;
   logic        load;
   logic        ack0_d;
   logic        ack1_d;
   logic        busy_d;

   assign any_req = bus.m0_req || bus.m1_req;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; WAIT leaves on the cycle the bridge data is valid
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (lat_cnt == 3'd1) next_state = ACK;
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output/datapath decode; these feed the output flops below.
   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      pick   = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
      load   = (state == IDLE) && any_req;
      ack0_d = (state == WAIT) && (lat_cnt == 3'd1) && !grant;
      ack1_d = (state == WAIT) && (lat_cnt == 3'd1) && grant;
      busy_d = (next_state != IDLE);
   end

   // Output and datapath registers. pr_addr/pr_wd/pr_be hold after ISSUE so
   // the bridge keeps seeing the address through WAIT; pr_we is a one-cycle
   // strobe. The captured pr_rd is steered only to the acked master.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant      <= 1'b0;
         last_grant <= M0_FIRST ? 1'b1 : 1'b0;
         lat_cnt    <= 3'd0;
         pr_addr_q  <= '0;
         pr_wd_q    <= '0;
         pr_be_q    <= '0;
         pr_we_q    <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_rd_q    <= '0;
         m1_rd_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         if (load) begin
            grant     <= pick;
            pr_addr_q <= pick ? bus.m1_addr : bus.m0_addr;
            pr_wd_q   <= pick ? bus.m1_wd   : bus.m0_wd;
            pr_be_q   <= pick ? bus.m1_be   : bus.m0_be;
            pr_we_q   <= pick ? bus.m1_we   : bus.m0_we;
         end else begin
            pr_we_q   <= 1'b0;
         end

         if (state == ISSUE) begin
            lat_cnt <= 3'(RD_LAT);
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
         end

         if (state == ACK) begin
            last_grant <= grant;
         end

         m0_ack_q <= ack0_d;
         m1_ack_q <= ack1_d;
         m0_rd_q  <= ack0_d ? bus.pr_rd : 32'd0;
         m1_rd_q  <= ack1_d ? bus.pr_rd : 32'd0;
         busy_q   <= busy_d;
      end
   end

   assign bus.pr_addr = pr_addr_q;
   assign bus.pr_wd   = pr_wd_q;
   assign bus.pr_be   = pr_be_q;
   assign bus.pr_we   = pr_we_q;
   assign bus.m0_ack  = m0_ack_q;
   assign bus.m1_ack  = m1_ack_q;
   assign bus.m0_rd   = m0_rd_q;
   assign bus.m1_rd   = m1_rd_q;
   assign bus.busy    = busy_q;

endmodule
